// File: rtl/adc_ltc2308_pkg.sv
// adc_ltc2308_pkg: shared types, widths and config-word builder for the LTC2308 sampler
package adc_ltc2308_pkg;
  localparam int DATA_W = 12;
  localparam int CFG_W = 6;
  localparam int CH_W = 3;
  typedef enum logic [2:0] {S_IDLE, S_CONVST, S_CONV, S_SHIFT, S_CAPTURE} state_t;
  // {S/D, O/S, S1, S0, UNI, SLP}; single-ended, sleep off
  function automatic logic [CFG_W-1:0] cfg_word(input logic [CH_W-1:0] ch, input logic uni);
    return {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
  endfunction
endpackage

// File: rtl/adc_ltc2308_chan_sel.sv
// adc_ltc2308_chan_sel: next set bit of mask strictly after last_ch, wrapping 7->0
// mask: channels enabled; last_ch: previous channel; next_ch: selected channel; found: mask non-empty
module adc_ltc2308_chan_sel import adc_ltc2308_pkg::*; (
  input  logic [7:0]      mask,
  input  logic [CH_W-1:0] last_ch,
  output logic [CH_W-1:0] next_ch,
  output logic            found
);
  // scan farthest-first so the nearest set bit after last_ch wins
  always_comb begin
    next_ch = '0;
    found = 1'b0;
    for (int i = 8; i >= 1; i--) begin
      if (mask[last_ch + CH_W'(i)]) begin
        next_ch = last_ch + CH_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adc_ltc2308_sampler.sv
// adc_ltc2308_sampler: round-robin LTC2308 frame sequencer with a one-slot valid/ready output
// clk/reset: system clock, sync active-high reset; enable/ch_mask/uni: scan control
// adc_convst/adc_sck/adc_sdi/adc_sdo: LTC2308 pins
// sample_data/sample_ch/sample_valid/sample_ready: output slot; busy: frame in progress
module adc_ltc2308_sampler import adc_ltc2308_pkg::*; #(
  parameter int CONV_CYCLES = 80,
  parameter int SCK_HALF = 2,
  parameter int CONVST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        ch_mask,
  input  logic              uni,
  output logic              adc_convst,
  output logic              adc_sck,
  output logic              adc_sdi,
  input  logic              adc_sdo,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy
);
  state_t state;
  int cnt;
  logic [3:0] bit_cnt;
  logic primed, found;
  logic [CH_W-1:0] cur_ch, last_ch, next_ch;
  logic [CFG_W-1:0] cfg_sr;
  logic [DATA_W-1:0] data_sr;
  // an unprimed scan restarts at bit 0 inclusive
  adc_ltc2308_chan_sel u_sel (
    .mask(ch_mask),
    .last_ch(primed ? last_ch : {CH_W{1'b1}}),
    .next_ch(next_ch),
    .found(found)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= 0;
      bit_cnt <= '0;
      adc_convst <= 1'b0;
      adc_sck <= 1'b0;
      adc_sdi <= 1'b0;
      sample_valid <= 1'b0;
      sample_data <= '0;
      sample_ch <= '0;
      busy <= 1'b0;
      primed <= 1'b0;
      last_ch <= {CH_W{1'b1}};
      cur_ch <= '0;
      cfg_sr <= '0;
      data_sr <= '0;
    end else begin
      if (sample_valid && sample_ready) sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!enable) primed <= 1'b0;
          if (enable && found && (!sample_valid || sample_ready)) begin
            state <= S_CONVST;
            adc_convst <= 1'b1;
            busy <= 1'b1;
            cnt <= 0;
            cur_ch <= next_ch;
            cfg_sr <= cfg_word(next_ch, uni);
          end
        end
        S_CONVST: begin
          if (cnt == CONVST_CYCLES - 1) begin
            state <= S_CONV;
            adc_convst <= 1'b0;
            cnt <= 0;
          end else cnt <= cnt + 1;
        end
        S_CONV: begin
          if (cnt == CONV_CYCLES - 1) begin
            state <= S_SHIFT;
            cnt <= 0;
            bit_cnt <= '0;
            adc_sdi <= cfg_sr[CFG_W-1];
          end else cnt <= cnt + 1;
        end
        S_SHIFT: begin
          if (cnt == SCK_HALF - 1) begin
            cnt <= 0;
            if (!adc_sck) begin
              adc_sck <= 1'b1;
              data_sr <= {data_sr[DATA_W-2:0], adc_sdo};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(DATA_W - 1)) state <= S_CAPTURE;
            end else begin
              adc_sck <= 1'b0;
              adc_sdi <= cfg_sr[CFG_W-2];
              cfg_sr <= cfg_sr << 1;
            end
          end else cnt <= cnt + 1;
        end
        // SCK stays high for the last high half; result is published on the first cycle
        S_CAPTURE: begin
          if (cnt == 0) begin
            if (primed) begin
              sample_valid <= 1'b1;
              sample_data <= data_sr;
              sample_ch <= last_ch;
            end
            primed <= 1'b1;
            last_ch <= cur_ch;
          end
          if (cnt == SCK_HALF - 1) begin
            state <= S_IDLE;
            adc_sck <= 1'b0;
            adc_sdi <= 1'b0;
            busy <= 1'b0;
            cnt <= 0;
          end else cnt <= cnt + 1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
